// File: rtl/sic1_pkg.sv
// Shared definitions for the SIC-1 memory arbiter slice.
//   owner_e      : tags who owns the read data returning next cycle
//   lock_state_e : arbiter lock state
//   SIC1_ADDR_W / SIC1_DATA_W : default memory geometry (256 x 8)
package sic1_pkg;

    localparam int unsigned SIC1_ADDR_W = 8;
    localparam int unsigned SIC1_DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    typedef enum logic {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/sic1_mem_arbiter_if.sv
// Requester-side memory port shared by the core and the host.
//   req/we/addr/wdata : request, held stable by the requester until req & gnt
//   gnt               : access accepted this cycle
//   rvalid/rdata      : read data, one cycle after an accepted read
// master = requester, slave = arbiter.
interface sic1_mem_arbiter_if
    import sic1_pkg::*;
#(
    parameter int unsigned ADDR_W = SIC1_ADDR_W,
    parameter int unsigned DATA_W = SIC1_DATA_W
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/sic1_sat_counter.sv
// Saturating event counter with increment enable.
//   clk   : clock
//   rst   : synchronous active-high clear
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
module sic1_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sic1_mem_arbiter.sv
// Round-robin arbiter sharing the SIC-1 256x8 single-port memory between the
// subleq core and the host load/debug port, with an atomic core lock.
//   clk, rst         : clock, synchronous active-high reset
//   core (slave)     : core request port
//   core_lock        : core keeps ownership after this access (RMW)
//   host (slave)     : host request port
//   mem_en/we/addr/wdata, mem_rdata : memory macro side
//   lock_err         : sticky, a lock timed out
//   stat_core/host/wait : 16-bit saturating statistics
// Build option: define SIC1_ARB_STATS_EN to build the statistics counters;
// otherwise the stat outputs are tied to zero.
module sic1_mem_arbiter
    import sic1_pkg::*;
#(
    parameter int unsigned ADDR_W   = SIC1_ADDR_W,
    parameter int unsigned DATA_W   = SIC1_DATA_W,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    sic1_mem_arbiter_if.slave core,
    input  logic              core_lock,
    sic1_mem_arbiter_if.slave host,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lock_err,
    output logic [15:0]       stat_core,
    output logic [15:0]       stat_host,
    output logic [15:0]       stat_wait
);

    localparam int unsigned LOCK_W = $clog2(LOCK_MAX + 1);

    lock_state_e       state_q, state_d;
    owner_e            last_q, last_d;
    owner_e            owner_q, owner_d;
    logic [LOCK_W-1:0] cnt_q, cnt_d;
    logic              lock_err_q, lock_err_d;

    logic core_gnt, host_gnt;
    logic core_acc, host_acc;

    assign core_acc = core.req & core_gnt;
    assign host_acc = host.req & host_gnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOCK_UNLOCKED;
            last_q     <= OWN_HOST;  // core wins the first contention
            owner_q    <= OWN_NONE;
            cnt_q      <= '0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lock_err_d = lock_err_q;
        unique case (state_q)
            LOCK_UNLOCKED: begin
                cnt_d = '0;
                if (core_acc && core_lock) begin
                    state_d = LOCK_LOCKED;
                end
            end
            LOCK_LOCKED: begin
                // A release accept wins over a timeout in the same cycle.
                if (core_acc && !core_lock) begin
                    state_d = LOCK_UNLOCKED;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_W'(LOCK_MAX - 1)) begin
                    state_d    = LOCK_UNLOCKED;
                    cnt_d      = '0;
                    lock_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + LOCK_W'(1);
                end
            end
            default: state_d = LOCK_UNLOCKED;
        endcase

        last_d = last_q;
        if (core_acc) begin
            last_d = OWN_CORE;
        end else if (host_acc) begin
            last_d = OWN_HOST;
        end

        owner_d = OWN_NONE;
        if (core_acc && !core.we) begin
            owner_d = OWN_CORE;
        end else if (host_acc && !host.we) begin
            owner_d = OWN_HOST;
        end
    end

    // Output logic: grants and memory steering. Everything is held off
    // during reset so no transfer can start and no stale read is returned.
    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (!rst) begin
            if (state_q == LOCK_LOCKED) begin
                core_gnt = core.req;
            end else if (core.req && host.req) begin
                core_gnt = (last_q != OWN_CORE);
                host_gnt = (last_q == OWN_CORE);
            end else begin
                core_gnt = core.req;
                host_gnt = host.req;
            end
        end

        mem_en    = core_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core.we;
            mem_addr  = core.addr;
            mem_wdata = core.wdata;
        end else if (host_gnt) begin
            mem_we    = host.we;
            mem_addr  = host.addr;
            mem_wdata = host.wdata;
        end
    end

    assign core.gnt    = core_gnt;
    assign host.gnt    = host_gnt;
    assign core.rvalid = !rst && (owner_q == OWN_CORE);
    assign host.rvalid = !rst && (owner_q == OWN_HOST);
    assign core.rdata  = core.rvalid ? mem_rdata : '0;
    assign host.rdata  = host.rvalid ? mem_rdata : '0;
    assign lock_err    = lock_err_q;

`ifdef SIC1_ARB_STATS_EN
    logic wait_inc;
    assign wait_inc = (core.req & ~core_gnt) | (host.req & ~host_gnt);

    sic1_sat_counter #(.WIDTH(16)) u_stat_core (
        .clk   (clk),
        .rst   (rst),
        .inc   (core_acc),
        .count (stat_core)
    );

    sic1_sat_counter #(.WIDTH(16)) u_stat_host (
        .clk   (clk),
        .rst   (rst),
        .inc   (host_acc),
        .count (stat_host)
    );

    sic1_sat_counter #(.WIDTH(16)) u_stat_wait (
        .clk   (clk),
        .rst   (rst),
        .inc   (wait_inc),
        .count (stat_wait)
    );
`else
    assign stat_core = '0;
    assign stat_host = '0;
    assign stat_wait = '0;
`endif

endmodule

// File: tb/tb_sic1_mem_arbiter.sv
// Self-checking bench for sic1_mem_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_sic1_mem_arbiter;
    import sic1_pkg::*;

    localparam int unsigned LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_lock;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr, mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        lock_err;
    logic [15:0] stat_core, stat_host, stat_wait;

    always #5 clk = ~clk;

    sic1_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) core_if ();
    sic1_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) host_if ();

    sic1_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .core      (core_if),
        .core_lock (core_lock),
        .host      (host_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .lock_err  (lock_err),
        .stat_core (stat_core),
        .stat_host (stat_host),
        .stat_wait (stat_wait)
    );

    // Memory macro: synchronous single-port RAM.
    logic [7:0] env_mem [256] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] ref_mem [256] = '{default: 8'h00};
    bit   m_locked, m_host_turn, m_err, m_cpend, m_hpend;
    int   m_age, m_sc, m_sh, m_sw;
    logic [7:0] m_cdata, m_hdata;
    bit   e_cg, e_hg;
    // Observed values from the last step, for directed checks
    bit   o_cg, o_hg, o_crv, o_hrv;
    logic [7:0] o_crd, o_hrd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_host_turn = 0; m_err = 0; m_cpend = 0; m_hpend = 0;
        m_age = 0; m_sc = 0; m_sh = 0; m_sw = 0;
    endtask

    task automatic drive(input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                         input bit cl, input bit hr, input bit hw, input logic [7:0] ha,
                         input logic [7:0] hd);
        core_if.req = cr; core_if.we = cw; core_if.addr = ca; core_if.wdata = cd;
        core_lock = cl;
        host_if.req = hr; host_if.we = hw; host_if.addr = ha; host_if.wdata = hd;
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // One cycle: inputs are already driven at posedge+1; check at the
    // falling edge, then advance the model across the rising edge.
    task automatic step();
        logic [16:0] exp_bus;
        #4;
        if (rst) begin
            e_cg = 0; e_hg = 0;
        end else if (m_locked) begin
            e_cg = core_if.req; e_hg = 0;
        end else if (core_if.req && host_if.req) begin
            e_cg = !m_host_turn; e_hg = m_host_turn;
        end else begin
            e_cg = core_if.req; e_hg = host_if.req;
        end
        o_cg = core_if.gnt; o_hg = host_if.gnt;
        o_crv = core_if.rvalid; o_hrv = host_if.rvalid;
        o_crd = core_if.rdata; o_hrd = host_if.rdata;

        check("gnt", {core_if.gnt, host_if.gnt}, {e_cg, e_hg});
        check("mem_en", mem_en, e_cg | e_hg);
        if (rst || e_cg || e_hg) begin
            if (e_cg)      exp_bus = {core_if.we, core_if.addr, core_if.wdata};
            else if (e_hg) exp_bus = {host_if.we, host_if.addr, host_if.wdata};
            else           exp_bus = '0;
            check("mem_bus", {mem_we, mem_addr, mem_wdata}, exp_bus);
        end
        check("core_rvalid", core_if.rvalid, !rst && m_cpend);
        check("core_rdata", core_if.rdata, (!rst && m_cpend) ? m_cdata : 8'h00);
        check("host_rvalid", host_if.rvalid, !rst && m_hpend);
        check("host_rdata", host_if.rdata, (!rst && m_hpend) ? m_hdata : 8'h00);
        check("lock_err", lock_err, m_err);
`ifdef SIC1_ARB_STATS_EN
        check("stat_core", stat_core, m_sc);
        check("stat_host", stat_host, m_sh);
        check("stat_wait", stat_wait, m_sw);
`else
        check("stat_off", {stat_core, stat_host, stat_wait}, 48'h0);
`endif

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_cpend = e_cg && !core_if.we;
            if (m_cpend) m_cdata = ref_mem[core_if.addr];
            m_hpend = e_hg && !host_if.we;
            if (m_hpend) m_hdata = ref_mem[host_if.addr];
            if (e_cg && core_if.we) ref_mem[core_if.addr] = core_if.wdata;
            if (e_hg && host_if.we) ref_mem[host_if.addr] = host_if.wdata;
            if (m_locked) begin
                m_age++;
                if (e_cg && !core_lock) begin
                    m_locked = 0;
                end else if (m_age == LOCK_MAX) begin
                    m_locked = 0;
                    m_err = 1;
                end
            end else if (e_cg && core_lock) begin
                m_locked = 1;
                m_age = 0;
            end
            if (e_cg) m_host_turn = 1;
            if (e_hg) m_host_turn = 0;
            if (e_cg) m_sc = sat16(m_sc + 1);
            if (e_hg) m_sh = sat16(m_sh + 1);
            if ((core_if.req && !e_cg) || (host_if.req && !e_hg)) m_sw = sat16(m_sw + 1);
        end
        #1;
    endtask

    initial begin
        bit [3:0] pat;
        int sw0;
        bit cp, hp;

        model_reset();
        rst = 1;
        drive(1, 0, 8'h01, 8'h00, 1, 1, 0, 8'h02, 8'h00);
        @(posedge clk);
        #1;
        // Reset with both requesting: nothing may be granted.
        step();
        check("rst_gnt", {o_cg, o_hg}, 2'b00);
        step();
        rst = 0;

        // Host write then read back.
        drive(0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h10, 8'h5A);
        step();
        check("wr_hgnt", o_hg, 1);
        drive(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h10, 8'h00);
        step();
        check("rd_hgnt", o_hg, 1);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        step();
        check("rd_hrvalid", o_hrv, 1);
        check("rd_hrdata", o_hrd, 8'h5A);

        // Continuous contention alternates, core first.
        sw0 = m_sw;
        drive(1, 0, 8'h30, 8'h00, 0, 1, 0, 8'h31, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            pat[3-i] = o_cg;
        end
        check("alternate", pat, 4'b1010);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        step();
`ifdef SIC1_ARB_STATS_EN
        check("wait4", stat_wait, sw0 + 4);
`endif

        // Locked RMW of 0x20: host read is held off until after the release.
        drive(1, 0, 8'h20, 8'h00, 1, 1, 0, 8'h20, 8'h00);
        step();
        check("rmw_cgnt", o_cg, 1);
        drive(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h20, 8'h00);
        step();
        check("rmw_hold1", o_hg, 0);
        drive(1, 1, 8'h20, 8'h77, 0, 1, 0, 8'h20, 8'h00);
        step();
        check("rmw_hold2", o_hg, 0);
        drive(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h20, 8'h00);
        step();
        check("rmw_hgnt", o_hg, 1);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        step();
        check("rmw_data", o_hrd, 8'h77);

        // Lock timeout: host waits LOCK_MAX cycles, then lock_err sticks.
        drive(1, 0, 8'h40, 8'h00, 1, 0, 0, 8'h00, 8'h00);
        step();
        drive(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h40, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step();
            check("to_hold", o_hg, 0);
        end
        step();
        check("to_hgnt", o_hg, 1);
        check("to_err", lock_err, 1);
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        repeat (3) step();
        check("err_sticky", lock_err, 1);

        // Reset right after a locked core read: rvalid dropped, lock released.
        drive(1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h00, 8'h00);
        step();
        rst = 1;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        step();
        check("rst_crvalid", o_crv, 0);
        rst = 0;
        step();
        check("post_rst_out", {mem_en, o_crv, o_hrv, lock_err}, 4'b0000);
        drive(0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h10, 8'h00);
        step();
        check("post_rst_hgnt", o_hg, 1);

        // Randomized traffic; requests are held until accepted.
        cp = 0; hp = 0;
        for (int n = 0; n < 600; n++) begin
            if (!cp) begin
                core_if.req = ($urandom_range(0, 3) != 0);
                core_if.we = 1'($urandom_range(0, 1));
                core_if.addr = 8'($urandom_range(0, 15));
                core_if.wdata = 8'($urandom);
                core_lock = ($urandom_range(0, 3) == 0);
            end
            if (!hp) begin
                host_if.req = ($urandom_range(0, 2) != 0);
                host_if.we = 1'($urandom_range(0, 1));
                host_if.addr = 8'($urandom_range(0, 15));
                host_if.wdata = 8'($urandom);
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
            cp = core_if.req && !e_cg;
            hp = host_if.req && !e_hg;
        end
        rst = 0;

`ifdef SIC1_ARB_STATS_EN
        // Saturation of the host accept counter.
        rst = 1;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        step();
        rst = 0;
        drive(0, 0, 8'h00, 8'h00, 0, 1, 1, 8'h00, 8'h00);
        repeat (70000) @(posedge clk);
        #5;
        check("sat_host", stat_host, 16'hFFFF);
        check("sat_core", stat_core, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
